tex_env_operand_stage: RTL and testbench

TEX_ENV_OPERAND_STAGE -- requirements
Module: tex_env_operand_stage

---
 rtl/tex_env_operand_stage_pkg.sv | 44 ++++
 rtl/tex_env_operand_stage_result.sv | 61 ++++++
 rtl/tex_env_operand_stage.sv | 190 +++++++++++++++++++
 tb/tb_tex_env_operand_stage.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tex_env_operand_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tex_env_operand_stage_pkg
// Purpose  : Shared pixel definitions for the texture-environment operand
//            stage: combine-mode encodings, fixed-point ONE / MINUS_ONE
//            constants, sub-pixel geometry and result FIFO sizing.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tex_env_operand_stage_pkg;

  // Default unsigned sub-pixel width and number of sub-pixels per pixel (RGBA)
  localparam int SUB_PIXEL_WIDTH_DEF = 8;
  localparam int NUM_SUB_PIXELS      = 4;

  // Fixed-point unity and its negation at the default sub-pixel width
  localparam int ONE       = (1 << SUB_PIXEL_WIDTH_DEF) - 1;
  localparam int MINUS_ONE = -ONE;

  // Result FIFO geometry; depth equals the credit limit of the stage
  localparam int RESULT_FIFO_DEPTH = 4;
  localparam int RESULT_FIFO_PTR_W = 2;
  localparam int RESULT_FIFO_CNT_W = 3;

  // Combine modes; encodings 5..7 fall back to REPLACE
  typedef enum logic [2:0] {
    MODE_REPLACE     = 3'd0,
    MODE_MODULATE    = 3'd1,
    MODE_ADD         = 3'd2,
    MODE_INTERPOLATE = 3'd3,
    MODE_SUBTRACT    = 3'd4
  } combine_mode_e;

  // Fixed-point unity for an arbitrary sub-pixel width
  function automatic int sp_one(input int width);
    return (1 << width) - 1;
  endfunction

  function automatic int sp_minus_one(input int width);
    return -sp_one(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tex_env_operand_stage_result.sv
`default_nettype none
// ============================================================================
// Module   : result_fifo
// Purpose  : 4-entry result buffer between the mixer return path and the
//            output handshake. Storage is cleared on reset so the read port
//            presents zero after reset.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            wr_en, wr_data  - write port (never asserted when full)
//            rd_en, rd_data  - read port, rd_data shows the head entry
//            count           - number of valid entries (0..4)
// Revision : 1.0 - initial release
// ============================================================================
module result_fifo
  import tex_env_operand_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             rd_data,
  output logic [RESULT_FIFO_CNT_W-1:0] count
);

  logic [WIDTH-1:0]             r_mem [RESULT_FIFO_DEPTH];
  logic [RESULT_FIFO_PTR_W-1:0] r_wr_ptr;
  logic [RESULT_FIFO_PTR_W-1:0] r_rd_ptr;
  logic [RESULT_FIFO_CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RESULT_FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (wr_en) begin
        r_mem[r_wr_ptr] <= wr_data;
        r_wr_ptr        <= r_wr_ptr + RESULT_FIFO_PTR_W'(1);
      end
      if (rd_en) begin
        r_rd_ptr <= r_rd_ptr + RESULT_FIFO_PTR_W'(1);
      end
      // Simultaneous write and read leaves the count unchanged
      case ({wr_en, rd_en})
        2'b10:   r_count <= r_count + RESULT_FIFO_CNT_W'(1);
        2'b01:   r_count <= r_count - RESULT_FIFO_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/tex_env_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tex_env_operand_stage
// Purpose  : Texture-environment operand stage. Selects per-sub-pixel mixer
//            operands (A*B + C*D) from the combine mode, registers them on
//            fragment acceptance, tracks each fragment through the external
//            2-cycle mixer, and buffers clamped results in a 4-entry FIFO.
//            Credit flow control keeps the mixer pipeline stall-free.
// Ports    : aclk, reset                         - clock, sync active-high reset
//            conf_valid/mode/constant            - combine configuration load
//            s_valid/ready/primary/texture/tag   - fragment input
//            colorA..D, mixedColor               - external mixer interface
//            m_valid/ready/color/tag             - result output
// Revision : 1.0 - initial release
// ============================================================================
module tex_env_operand_stage
  import tex_env_operand_stage_pkg::*;
#(
  parameter int SUB_PIXEL_WIDTH = SUB_PIXEL_WIDTH_DEF,
  parameter int TAG_WIDTH       = 16
) (
  input  logic                           aclk,
  input  logic                           reset,
  input  logic                           conf_valid,
  input  logic [2:0]                     conf_mode,
  input  logic [4*SUB_PIXEL_WIDTH-1:0]   conf_constant,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [4*SUB_PIXEL_WIDTH-1:0]   s_primary,
  input  logic [4*SUB_PIXEL_WIDTH-1:0]   s_texture,
  input  logic [TAG_WIDTH-1:0]           s_tag,
  output logic [4*(SUB_PIXEL_WIDTH+1)-1:0] colorA,
  output logic [4*(SUB_PIXEL_WIDTH+1)-1:0] colorB,
  output logic [4*(SUB_PIXEL_WIDTH+1)-1:0] colorC,
  output logic [4*(SUB_PIXEL_WIDTH+1)-1:0] colorD,
  input  logic [4*(SUB_PIXEL_WIDTH+1)-1:0] mixedColor,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [4*SUB_PIXEL_WIDTH-1:0]   m_color,
  output logic [TAG_WIDTH-1:0]           m_tag
);

  localparam int SPW      = SUB_PIXEL_WIDTH;
  localparam int SP1      = SUB_PIXEL_WIDTH + 1;
  localparam int OPW      = NUM_SUB_PIXELS * SP1;
  localparam int ONE_I    = sp_one(SUB_PIXEL_WIDTH);
  localparam int MONE_I   = sp_minus_one(SUB_PIXEL_WIDTH);
  localparam logic [SP1-1:0] LANE_ONE  = ONE_I[SP1-1:0];
  localparam logic [SP1-1:0] LANE_MONE = MONE_I[SP1-1:0];
  localparam int FIFO_W   = NUM_SUB_PIXELS * SPW + TAG_WIDTH;

  logic [2:0]                   r_mode;
  logic [4*SPW-1:0]             r_constant;
  logic [OPW-1:0]               w_op_a, w_op_b, w_op_c, w_op_d;
  logic [OPW-1:0]               r_color_a, r_color_b, r_color_c, r_color_d;
  logic [2:0]                   r_vld;
  logic [TAG_WIDTH-1:0]         r_tag_sr [3];
  logic [RESULT_FIFO_CNT_W-1:0] r_in_flight;
  logic [RESULT_FIFO_CNT_W-1:0] w_fifo_count;
  logic [RESULT_FIFO_CNT_W:0]   w_occupancy;
  logic [4*SPW-1:0]             w_clamped;
  logic [FIFO_W-1:0]            w_rd_data;
  logic                         w_accept;
  logic                         w_fifo_rd;

  assign w_accept  = s_valid & s_ready;
  assign w_fifo_rd = m_valid & m_ready;

  // Credit rule: fragments in the mixer plus buffered results never exceed
  // the FIFO depth, so the mixer return path can always be absorbed.
  assign w_occupancy = {1'b0, r_in_flight} + {1'b0, w_fifo_count};
  assign s_ready     = w_occupancy < (RESULT_FIFO_CNT_W + 1)'(RESULT_FIFO_DEPTH);

  // Configuration: a fragment accepted in the load cycle sees the old value
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_mode     <= MODE_REPLACE;
      r_constant <= '0;
    end else if (conf_valid) begin
      r_mode     <= conf_mode;
      r_constant <= conf_constant;
    end
  end

  // Per-sub-pixel operand selection and result clamping
  for (genvar i = 0; i < NUM_SUB_PIXELS; i++) begin : g_lane
    logic [SP1-1:0] lane_prim, lane_tex, lane_cst;
    logic [SP1-1:0] lane_a, lane_b, lane_c, lane_d;

    assign lane_prim = {1'b0, s_primary[i*SPW +: SPW]};
    assign lane_tex  = {1'b0, s_texture[i*SPW +: SPW]};
    assign lane_cst  = {1'b0, r_constant[i*SPW +: SPW]};

    always_comb begin
      lane_a = lane_tex;
      lane_b = LANE_ONE;
      lane_c = '0;
      lane_d = '0;
      case (r_mode)
        MODE_MODULATE: begin
          lane_a = lane_prim;
          lane_b = lane_tex;
        end
        MODE_ADD: begin
          lane_a = lane_prim;
          lane_c = lane_tex;
          lane_d = LANE_ONE;
        end
        MODE_INTERPOLATE: begin
          lane_b = lane_cst;
          lane_c = lane_prim;
          lane_d = LANE_ONE - lane_cst;
        end
        MODE_SUBTRACT: begin
          lane_a = lane_prim;
          lane_c = lane_tex;
          lane_d = LANE_MONE;
        end
        default: begin
        end
      endcase
    end

    assign w_op_a[i*SP1 +: SP1] = lane_a;
    assign w_op_b[i*SP1 +: SP1] = lane_b;
    assign w_op_c[i*SP1 +: SP1] = lane_c;
    assign w_op_d[i*SP1 +: SP1] = lane_d;

    // The mixer saturates high itself; only negative results need clamping
    assign w_clamped[i*SPW +: SPW] = mixedColor[i*SP1 + SPW] ? '0
                                   : mixedColor[i*SP1 +: SPW];
  end

  // Operand registers hold their value between accepted fragments
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_color_a <= '0;
      r_color_b <= '0;
      r_color_c <= '0;
      r_color_d <= '0;
    end else if (w_accept) begin
      r_color_a <= w_op_a;
      r_color_b <= w_op_b;
      r_color_c <= w_op_c;
      r_color_d <= w_op_d;
    end
  end

  assign colorA = r_color_a;
  assign colorB = r_color_b;
  assign colorC = r_color_c;
  assign colorD = r_color_d;

  // Stage 0 aligns with the operand registers, stage 2 with mixedColor
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_vld       <= '0;
      r_in_flight <= '0;
    end else begin
      r_vld       <= {r_vld[1:0], w_accept};
      r_in_flight <= r_in_flight + RESULT_FIFO_CNT_W'(w_accept)
                                 - RESULT_FIFO_CNT_W'(r_vld[2]);
    end
  end

  // Tags need no reset: validity is carried by r_vld alone
  always_ff @(posedge aclk) begin
    r_tag_sr[0] <= s_tag;
    r_tag_sr[1] <= r_tag_sr[0];
    r_tag_sr[2] <= r_tag_sr[1];
  end

  result_fifo #(
    .WIDTH (FIFO_W)
  ) u_result_fifo (
    .clk     (aclk),
    .rst     (reset),
    .wr_en   (r_vld[2]),
    .wr_data ({w_clamped, r_tag_sr[2]}),
    .rd_en   (w_fifo_rd),
    .rd_data (w_rd_data),
    .count   (w_fifo_count)
  );

  assign m_valid = (w_fifo_count != '0);
  assign m_color = w_rd_data[FIFO_W-1 -: 4*SPW];
  assign m_tag   = w_rd_data[TAG_WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_tex_env_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_tex_env_operand_stage
// Purpose  : Self-checking bench for tex_env_operand_stage with a behavioural
//            2-cycle mixer, a per-mode reference model and a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tex_env_operand_stage;

  logic        aclk = 1'b0;
  logic        reset;
  logic        conf_valid;
  logic [2:0]  conf_mode;
  logic [31:0] conf_constant;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_primary;
  logic [31:0] s_texture;
  logic [15:0] s_tag;
  logic [35:0] colorA, colorB, colorC, colorD;
  logic [35:0] mixedColor;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_color;
  logic [15:0] m_tag;

  tex_env_operand_stage dut (
    .aclk          (aclk),
    .reset         (reset),
    .conf_valid    (conf_valid),
    .conf_mode     (conf_mode),
    .conf_constant (conf_constant),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_primary     (s_primary),
    .s_texture     (s_texture),
    .s_tag         (s_tag),
    .colorA        (colorA),
    .colorB        (colorB),
    .colorC        (colorC),
    .colorD        (colorD),
    .mixedColor    (mixedColor),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_color       (m_color),
    .m_tag         (m_tag)
  );

  always #5 aclk = ~aclk;

  // Behavioural mixer: per lane (A*B + C*D)/ONE, saturated to 9-bit signed
  function automatic logic [35:0] mix(input logic [35:0] a, b, c, d);
    logic [35:0] r;
    int av, bv, cv, dv, s;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      av = int'($signed(a[i*9 +: 9]));
      bv = int'($signed(b[i*9 +: 9]));
      cv = int'($signed(c[i*9 +: 9]));
      dv = int'($signed(d[i*9 +: 9]));
      s  = (av * bv + cv * dv) / 255;
      if (s > 255)  s = 255;
      if (s < -256) s = -256;
      r[i*9 +: 9] = s[8:0];
    end
    return r;
  endfunction

  logic [35:0] mix_p1 = '0;
  logic [35:0] mix_p2 = '0;
  always @(posedge aclk) begin
    mix_p1 <= mix(colorA, colorB, colorC, colorD);
    mix_p2 <= mix_p1;
  end
  assign mixedColor = mix_p2;

  // Reference: final output colour from the combine rules directly
  function automatic logic [31:0] ref_color(input logic [2:0] mode,
                                            input logic [31:0] k, p, t);
    logic [31:0] r;
    int pi, ti, ki, v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      pi = int'(p[i*8 +: 8]);
      ti = int'(t[i*8 +: 8]);
      ki = int'(k[i*8 +: 8]);
      case (mode)
        3'd1:    v = pi * ti / 255;
        3'd2:    v = (pi + ti > 255) ? 255 : pi + ti;
        3'd3:    v = (ti * ki + pi * (255 - ki)) / 255;
        3'd4:    v = (pi - ti < 0) ? 0 : pi - ti;
        default: v = ti;
      endcase
      r[i*8 +: 8] = v[7:0];
    end
    return r;
  endfunction

  function automatic logic [35:0] zext36(input logic [31:0] x);
    return {1'b0, x[31:24], 1'b0, x[23:16], 1'b0, x[15:8], 1'b0, x[7:0]};
  endfunction

  typedef struct {
    logic [31:0] color;
    logic [15:0] tag;
  } exp_t;

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] cst;
    logic [31:0] prim;
    logic [31:0] tex;
    logic [15:0] tag;
    logic [31:0] exp_color;
  } vec_t;

  exp_t        exp_q[$];
  logic [2:0]  mdl_mode;
  logic [31:0] mdl_const;
  int          errors = 0;
  int          checks = 0;
  bit          last_accept;
  vec_t        vecs[11];
  logic [31:0] data34[10];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Evaluate the handshakes for the coming edge, then advance one cycle and
  // return #1 after the following falling edge.
  task automatic step();
    exp_t e;
    last_accept = 1'b0;
    if (reset) begin
      exp_q.delete();
      mdl_mode  = 3'd0;
      mdl_const = '0;
    end else begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got color %0h tag %0h, required none",
                   m_color, m_tag);
        end else begin
          e = exp_q.pop_front();
          check("sb_color", 64'(m_color), 64'(e.color));
          check("sb_tag", 64'(m_tag), 64'(e.tag));
        end
      end
      if (s_valid && s_ready) begin
        e.color = ref_color(mdl_mode, mdl_const, s_primary, s_texture);
        e.tag   = s_tag;
        exp_q.push_back(e);
        last_accept = 1'b1;
      end
      if (conf_valid) begin
        mdl_mode  = conf_mode;
        mdl_const = conf_constant;
      end
    end
    @(posedge aclk);
    @(negedge aclk);
    #1;
  endtask

  task automatic configure(input logic [2:0] mode, input logic [31:0] cst);
    conf_valid = 1'b1; conf_mode = mode; conf_constant = cst;
    step();
    conf_valid = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (m_valid) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check({name, "_timeout"}, 64'(seen), 64'd1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    s_valid = 1'b0; conf_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && !m_valid) begin
        done = 1'b1;
        break;
      end
      step();
    end
    check("drain_complete", 64'(done), 64'd1);
  endtask

  initial begin
    int j;
    vecs[0]  = '{3'd1, 32'h0,        32'h80808080, 32'hFFFFFFFF, 16'h1234, 32'h80808080};
    vecs[1]  = '{3'd4, 32'h0,        32'h10101010, 32'h40404040, 16'hBEEF, 32'h00000000};
    vecs[2]  = '{3'd2, 32'h0,        32'hC0C0C0C0, 32'hC0C0C0C0, 16'hA5A5, 32'hFFFFFFFF};
    vecs[3]  = '{3'd0, 32'h0,        32'h11223344, 32'h55667788, 16'h0001, 32'h55667788};
    vecs[4]  = '{3'd5, 32'h0,        32'h11223344, 32'h01020304, 16'h0002, 32'h01020304};
    vecs[5]  = '{3'd7, 32'h0,        32'h11223344, 32'h9ABCDEF0, 16'h0003, 32'h9ABCDEF0};
    vecs[6]  = '{3'd3, 32'h00000000, 32'h13579BDF, 32'h2468ACE0, 16'h0004, 32'h13579BDF};
    vecs[7]  = '{3'd3, 32'hFFFFFFFF, 32'h13579BDF, 32'h2468ACE0, 16'h0005, 32'h2468ACE0};
    vecs[8]  = '{3'd1, 32'h0,        32'hFF00FF80, 32'h80FF0040, 16'h0006, 32'h80000020};
    vecs[9]  = '{3'd2, 32'h0,        32'h10203040, 32'h01020304, 16'h0007, 32'h11223344};
    vecs[10] = '{3'd4, 32'h0,        32'h80404010, 32'h20404080, 16'h0008, 32'h60000000};

    reset = 1'b1; conf_valid = 1'b0; conf_mode = '0; conf_constant = '0;
    s_valid = 1'b0; s_primary = '0; s_texture = '0; s_tag = '0; m_ready = 1'b0;
    mdl_mode = '0; mdl_const = '0;
    @(negedge aclk);
    #1;
    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_color", 64'(m_color), 64'd0);
    check("rst_m_tag", 64'(m_tag), 64'd0);
    check("rst_colorA", 64'(colorA), 64'd0);
    check("rst_colorD", 64'(colorD), 64'd0);

    // Latency: accept at edge k, m_valid first seen after edge k+3
    configure(3'd1, 32'h0);
    s_valid = 1'b1; s_primary = 32'h80808080; s_texture = 32'hFFFFFFFF; s_tag = 16'h00C3;
    step();
    s_valid = 1'b0;
    check("lat_k0", 64'(m_valid), 64'd0);
    check("lat_opA", 64'(colorA), 64'(zext36(32'h80808080)));
    check("lat_opB", 64'(colorB), 64'(zext36(32'hFFFFFFFF)));
    step();
    check("lat_k1", 64'(m_valid), 64'd0);
    step();
    check("lat_k2", 64'(m_valid), 64'd0);
    step();
    check("lat_k3", 64'(m_valid), 64'd1);
    check("lat_color", 64'(m_color), 64'h80808080);
    check("lat_tag", 64'(m_tag), 64'h00C3);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    check("lat_empty", 64'(m_valid), 64'd0);

    // Table of single-fragment vectors
    for (int v = 0; v < 11; v++) begin
      configure(vecs[v].mode, vecs[v].cst);
      s_valid = 1'b1; s_primary = vecs[v].prim; s_texture = vecs[v].tex; s_tag = vecs[v].tag;
      step();
      s_valid = 1'b0;
      wait_valid("vec_wait");
      check($sformatf("vec%0d_color", v), 64'(m_color), 64'(vecs[v].exp_color));
      check($sformatf("vec%0d_tag", v), 64'(m_tag), 64'(vecs[v].tag));
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
    end

    // Config change in the same cycle as an accept
    configure(3'd1, 32'h0);
    conf_valid = 1'b1; conf_mode = 3'd3; conf_constant = 32'h0;
    s_valid = 1'b1; s_primary = 32'h40404040; s_texture = 32'h80808080; s_tag = 16'h0A0A;
    step();
    conf_valid = 1'b0;
    check("cfg_old_opA", 64'(colorA), 64'(zext36(32'h40404040)));
    check("cfg_old_opB", 64'(colorB), 64'(zext36(32'h80808080)));
    s_primary = 32'h11223344; s_texture = 32'h55667788; s_tag = 16'h0B0B;
    step();
    s_valid = 1'b0;
    check("cfg_new_opA", 64'(colorA), 64'(zext36(32'h55667788)));
    check("cfg_new_opB", 64'(colorB), 64'd0);
    check("cfg_new_opC", 64'(colorC), 64'(zext36(32'h11223344)));
    check("cfg_new_opD", 64'(colorD), 64'(zext36(32'hFFFFFFFF)));
    wait_valid("cfg_wait_a");
    check("cfg_old_color", 64'(m_color), 64'h20202020);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    wait_valid("cfg_wait_b");
    check("cfg_new_color", 64'(m_color), 64'h11223344);
    drain();

    // Backpressure: 10 back-to-back fragments with m_ready low
    configure(3'd0, 32'h0);
    for (int i = 0; i < 10; i++) data34[i] = $urandom;
    j = 0;
    m_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      s_valid = 1'b1; s_primary = $urandom; s_texture = data34[j]; s_tag = 16'(j);
      step();
      if (last_accept) j++;
    end
    s_valid = 1'b0;
    check("bp_accepted", 64'(j), 64'd4);
    check("bp_s_ready", 64'(s_ready), 64'd0);
    m_ready = 1'b1;
    for (int c = 0; c < 200 && j < 10; c++) begin
      s_valid = 1'b1; s_primary = $urandom; s_texture = data34[j]; s_tag = 16'(j);
      step();
      if (last_accept) j++;
    end
    s_valid = 1'b0;
    check("bp_all_sent", 64'(j), 64'd10);
    drain();

    // Randomised traffic against the reference model
    for (int c = 0; c < 500; c++) begin
      conf_valid    = ($urandom_range(0, 19) == 0);
      conf_mode     = 3'($urandom_range(0, 7));
      conf_constant = $urandom;
      s_valid       = ($urandom_range(0, 9) < 7);
      s_primary     = $urandom;
      s_texture     = $urandom;
      s_tag         = 16'($urandom);
      m_ready       = ($urandom_range(0, 9) < 6);
      step();
    end
    conf_valid = 1'b0;
    drain();

    // Reset with two fragments in flight and two buffered
    m_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      s_valid = 1'b1; s_primary = $urandom; s_texture = $urandom; s_tag = 16'(100 + c);
      step();
    end
    s_valid = 1'b0;
    step();
    check("mid_m_valid", 64'(m_valid), 64'd1);
    check("mid_s_ready", 64'(s_ready), 64'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_m_valid", 64'(m_valid), 64'd0);
    check("mrst_s_ready", 64'(s_ready), 64'd1);
    check("mrst_m_color", 64'(m_color), 64'd0);
    check("mrst_m_tag", 64'(m_tag), 64'd0);
    m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check("mrst_no_stale", 64'(m_valid), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
